// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with a two-entry skid buffer, flush,
// occupancy report and saturating back-pressure counter.
module pipe_stage_reg #(
  parameter int              WIDTH          = 32,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0,
  parameter bit              CLEAR_ON_FLUSH = 1'b0,
  parameter int              CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  logic [1:0]       state_p0;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] main_p0;
  logic [WIDTH-1:0] skid_p0;
  logic             load_main;
  logic             load_skid;
  logic             main_from_skid;
  logic             stall_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_nxt      = state_p0;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_p0)
      EMPTY: begin
        if (in_valid) begin
          load_main = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (in_valid && out_ready) begin
          load_main = 1'b1;
        end else if (in_valid) begin
          load_skid = 1'b1;
          state_nxt = STALL;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      STALL: begin
        if (out_ready) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush drops held and incoming data; any output transfer this cycle has already been seen.
    if (flush) begin
      state_nxt      = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  // ---- stage p0: control, payload and stall counter registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0 <= EMPTY;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_p0 <= RESET_VAL;
      skid_p0 <= RESET_VAL;
    end else if (flush && CLEAR_ON_FLUSH) begin
      main_p0 <= RESET_VAL;
      skid_p0 <= RESET_VAL;
    end else begin
      if (load_main) main_p0 <= main_from_skid ? skid_p0 : in_data;
      if (load_skid) skid_p0 <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_now) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign in_ready  = (state_p0 != STALL);
  assign out_valid = (state_p0 != EMPTY);
  assign out_data  = main_p0;
  assign occupancy = state_p0;
  assign stall_now = out_valid & ~out_ready;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, reset/flush/saturation
// sequences and randomized handshake traffic checked against queue scoreboards.
module tb_pipe_stage_reg;

  localparam logic [31:0] RV_A = 32'h5A5A_0001;
  localparam logic [7:0]  RV_B = 8'hA5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // DUT A: 32-bit, data held on flush
  logic a_fl, a_iv, a_ir, a_ov, a_or;
  logic [31:0] a_id, a_od;
  logic [1:0]  a_occ;
  logic [15:0] a_cnt;
  // DUT B: 8-bit, cleared on flush, 4-bit counter
  logic b_fl, b_iv, b_ir, b_ov, b_or;
  logic [7:0] b_id, b_od;
  logic [1:0] b_occ;
  logic [3:0] b_cnt;
  // DUT C: 64-bit
  logic c_fl, c_iv, c_ir, c_ov, c_or;
  logic [63:0] c_id, c_od;
  logic [1:0]  c_occ;
  logic [15:0] c_cnt;

  pipe_stage_reg #(.WIDTH(32), .RESET_VAL(RV_A), .CLEAR_ON_FLUSH(1'b0), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .flush(a_fl), .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
    .out_valid(a_ov), .out_data(a_od), .out_ready(a_or), .occupancy(a_occ), .stall_cnt(a_cnt));

  pipe_stage_reg #(.WIDTH(8), .RESET_VAL(RV_B), .CLEAR_ON_FLUSH(1'b1), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .flush(b_fl), .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
    .out_valid(b_ov), .out_data(b_od), .out_ready(b_or), .occupancy(b_occ), .stall_cnt(b_cnt));

  pipe_stage_reg #(.WIDTH(64), .RESET_VAL(64'h0), .CLEAR_ON_FLUSH(1'b0), .CNT_W(16)) dut_c (
    .clk(clk), .reset(reset), .flush(c_fl), .in_valid(c_iv), .in_data(c_id), .in_ready(c_ir),
    .out_valid(c_ov), .out_data(c_od), .out_ready(c_or), .occupancy(c_occ), .stall_cnt(c_cnt));

  int checks = 0;
  int errors = 0;
  logic [63:0] qb[$];
  logic [63:0] qc[$];

  typedef struct packed {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        ov;
    logic        ir;
    logic [1:0]  occ;
    logic [31:0] od;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(bit fl, bit iv, logic [31:0] d, bit ordy,
                              bit ov, bit ir, int occ, logic [31:0] od, int cnt);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ov = ov; v.ir = ir; v.occ = occ[1:0]; v.od = od; v.cnt = cnt[15:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic a_cycle(input bit fl, input bit iv, input logic [31:0] d, input bit ordy);
    @(negedge clk);
    a_fl = fl; a_iv = iv; a_id = d; a_or = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic b_cycle(input bit fl, input bit iv, input logic [7:0] d, input bit ordy);
    @(negedge clk);
    b_fl = fl; b_iv = iv; b_id = d; b_or = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_step(input bit drain, input bit probe);
    logic ir_b, ir_c, ov_b, ov_c;
    @(negedge clk);
    b_iv = drain ? 1'b0 : ($urandom_range(0, 9) < 7);
    b_or = drain ? 1'b1 : ($urandom_range(0, 9) < 6);
    b_id = 8'($urandom);
    c_iv = drain ? 1'b0 : ($urandom_range(0, 9) < 7);
    c_or = drain ? 1'b1 : ($urandom_range(0, 9) < 5);
    c_id = {$urandom, $urandom};
    chk("occ_b", 64'(b_occ), 64'(qb.size()));
    chk("occ_c", 64'(c_occ), 64'(qc.size()));
    if (probe) begin
      ir_b = b_ir; ir_c = c_ir; ov_b = b_ov; ov_c = c_ov;
      b_or = ~b_or; c_or = ~c_or;
      #1;
      chk("in_ready_vs_out_ready_b", 64'(b_ir), 64'(ir_b));
      chk("in_ready_vs_out_ready_c", 64'(c_ir), 64'(ir_c));
      chk("out_valid_vs_out_ready_b", 64'(b_ov), 64'(ov_b));
      chk("out_valid_vs_out_ready_c", 64'(c_ov), 64'(ov_c));
      b_or = ~b_or; c_or = ~c_or;
      #1;
    end
    if (b_ov) begin
      if (qb.size() == 0) chk("extra_out_b", 64'd1, 64'd0);
      else begin
        chk("data_b", 64'(b_od), qb[0]);
        if (b_or) void'(qb.pop_front());
      end
    end
    if (b_iv && b_ir) qb.push_back(64'(b_id));
    if (c_ov) begin
      if (qc.size() == 0) chk("extra_out_c", 64'd1, 64'd0);
      else begin
        chk("data_c", c_od, qc[0]);
        if (c_or) void'(qc.pop_front());
      end
    end
    if (c_iv && c_ir) qc.push_back(c_id);
  endtask

  initial begin
    a_fl = 0; a_iv = 0; a_id = '0; a_or = 0;
    b_fl = 0; b_iv = 0; b_id = '0; b_or = 0;
    c_fl = 0; c_iv = 0; c_id = '0; c_or = 0;

    // streaming, back-pressure, flush in STALL, flush with output transfer
    tbl[0]  = mk(0, 1, 32'h1,  1, 1, 1, 1, 32'h1,  0);
    tbl[1]  = mk(0, 1, 32'h2,  1, 1, 1, 1, 32'h2,  0);
    tbl[2]  = mk(0, 1, 32'h3,  1, 1, 1, 1, 32'h3,  0);
    tbl[3]  = mk(0, 0, 32'h0,  1, 0, 1, 0, 32'h3,  0);
    tbl[4]  = mk(0, 1, 32'hA,  0, 1, 1, 1, 32'hA,  0);
    tbl[5]  = mk(0, 1, 32'hB,  0, 1, 0, 2, 32'hA,  1);
    tbl[6]  = mk(0, 1, 32'hD,  0, 1, 0, 2, 32'hA,  2);
    tbl[7]  = mk(0, 0, 32'h0,  1, 1, 1, 1, 32'hB,  2);
    tbl[8]  = mk(0, 0, 32'h0,  1, 0, 1, 0, 32'hB,  2);
    tbl[9]  = mk(0, 1, 32'h11, 0, 1, 1, 1, 32'h11, 2);
    tbl[10] = mk(0, 1, 32'h12, 0, 1, 0, 2, 32'h11, 3);
    tbl[11] = mk(1, 1, 32'hC,  0, 0, 1, 0, 32'h11, 4);
    tbl[12] = mk(0, 0, 32'h0,  1, 0, 1, 0, 32'h11, 4);
    tbl[13] = mk(0, 1, 32'h21, 1, 1, 1, 1, 32'h21, 4);
    tbl[14] = mk(1, 1, 32'h22, 1, 0, 1, 0, 32'h21, 4);
    tbl[15] = mk(0, 0, 32'h0,  1, 0, 1, 0, 32'h21, 4);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(a_ov), 64'd0);
    chk("rst_in_ready", 64'(a_ir), 64'd1);
    chk("rst_occ", 64'(a_occ), 64'd0);
    chk("rst_out_data", 64'(a_od), 64'(RV_A));
    chk("rst_cnt_c", 64'(c_cnt), 64'd0);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 16; i++) begin
      a_cycle(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk($sformatf("v%0d_out_valid", i), 64'(a_ov), 64'(tbl[i].ov));
      chk($sformatf("v%0d_in_ready", i), 64'(a_ir), 64'(tbl[i].ir));
      chk($sformatf("v%0d_occ", i), 64'(a_occ), 64'(tbl[i].occ));
      chk($sformatf("v%0d_out_data", i), 64'(a_od), 64'(tbl[i].od));
      chk($sformatf("v%0d_stall_cnt", i), 64'(a_cnt), 64'(tbl[i].cnt));
    end

    // asynchronous reset while in STALL
    a_cycle(0, 1, 32'h31, 0);
    a_cycle(0, 1, 32'h32, 0);
    chk("pre_rst_occ", 64'(a_occ), 64'd2);
    #2;
    reset = 1;
    #1;
    chk("arst_out_valid", 64'(a_ov), 64'd0);
    chk("arst_in_ready", 64'(a_ir), 64'd1);
    chk("arst_occ", 64'(a_occ), 64'd0);
    chk("arst_out_data", 64'(a_od), 64'(RV_A));
    chk("arst_cnt", 64'(a_cnt), 64'd0);
    @(negedge clk);
    reset = 0;
    a_cycle(0, 1, 32'h41, 1);
    chk("post_rst_out_data", 64'(a_od), 64'h41);
    chk("post_rst_occ", 64'(a_occ), 64'd1);
    a_cycle(0, 0, 32'h0, 1);

    // saturation on the 4-bit counter
    b_cycle(0, 1, 8'h77, 0);
    for (int k = 1; k <= 20; k++) begin
      b_cycle(0, 0, 8'h0, 0);
      if (k == 14) chk("sat_cnt_14", 64'(b_cnt), 64'd14);
    end
    chk("sat_cnt_15", 64'(b_cnt), 64'd15);
    chk("sat_out_data", 64'(b_od), 64'h77);

    // flush in STALL with clear-on-flush
    b_cycle(0, 1, 8'h78, 0);
    chk("b_stall_occ", 64'(b_occ), 64'd2);
    b_cycle(1, 1, 8'h0C, 0);
    chk("b_flush_occ", 64'(b_occ), 64'd0);
    chk("b_flush_out_valid", 64'(b_ov), 64'd0);
    chk("b_flush_out_data", 64'(b_od), 64'(RV_B));
    b_cycle(0, 0, 8'h0, 1);
    chk("b_flush_hold_valid", 64'(b_ov), 64'd0);
    chk("b_flush_hold_data", 64'(b_od), 64'(RV_B));

    // randomized traffic on the 8-bit and 64-bit instances
    for (int i = 0; i < 10000; i++) rnd_step(1'b0, (i % 16) == 0);
    for (int i = 0; i < 4; i++) rnd_step(1'b1, 1'b0);
    chk("drain_b", 64'(qb.size()), 64'd0);
    chk("drain_c", 64'(qc.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
